// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the serial adder/subtractor
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell shared with the parallel unit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - bit-serial LSB-first adder/subtractor with per-stage carry chain
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  // Counter only needs to reach WIDTH; WIDTH must be at least 2 so c[WIDTH-2] exists.
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  // A new operation is taken only when no bits are in flight.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (count == CW'(WIDTH - 1));

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: WIDTH bit-cycles in SHIFT, one cycle in DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode directly from state, so reset clears them at once.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on accept, then one full-adder step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      count <= '0;
      s     <= '0;
      c     <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      // Subtract as A + ~B + 1: invert B here, the +1 enters as the initial carry.
      op_b  <= b ^ {WIDTH{m}};
      carry <= (m == MODE_SUB);
      count <= '0;
      s     <= '0;
      c     <= '0;
      ovf   <= 1'b0;
    end else if (state == SHIFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (count == CW'(i)) begin
          s[i] <= fa_sum;
          c[i] <= fa_cout;
        end
      end
      carry <= fa_cout;
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      count <= count + CW'(1);
      if (last_bit) begin
        ovf <= fa_cout ^ c[WIDTH-2];
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - scoreboard bench for the serial adder/subtractor
module tb_addsub_serial;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         m;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic [W-1:0] c;
  logic         ovf;

  int   n_checks;
  int   n_fail;
  int   n;
  int   pulses;
  res_t sb[$];

  addsub_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry out of stage i is bit i+1 of the arithmetic sum of the low i+1 bits.
  function automatic res_t ref_calc(input logic [W-1:0] av, input logic [W-1:0] bv, input logic mv);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   part;
    logic [W-1:0] mask;
    bb = mv ? ~bv : bv;
    for (int i = 0; i < W; i++) begin
      mask = W'((1 << (i + 1)) - 1);
      part = {1'b0, av & mask} + {1'b0, bb & mask} + (W+1)'(mv);
      r.c[i] = part[i+1];
    end
    r.s   = mv ? (av - bv) : (av + bv);
    r.ovf = r.c[W-1] ^ r.c[W-2];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_s"}, 32'(s), 32'(e.s));
      check({tag, "_c"}, 32'(c), 32'(e.c));
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic mv);
    int cnt;
    @(negedge clk);
    a = av; b = bv; m = mv; start = 1'b1;
    @(posedge clk);
    sb.push_back(ref_calc(av, bv, mv));
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cnt);
    check({tag, "_lat"}, 32'(cnt), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; m = 1'b0;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // directed cases
    run_op("add_4_10", 4'd4, 4'd10, 1'b0);
    run_op("add_7_12", 4'd7, 4'd12, 1'b0);
    check("add_7_12_c_lit", 32'(c), 32'b1100);
    run_op("sub_4_10", 4'd4, 4'd10, 1'b1);
    check("sub_4_10_ovf_lit", 32'(ovf), 32'd1);
    run_op("add_7_1", 4'd7, 4'd1, 1'b0);
    check("add_7_1_s_lit", 32'(s), 32'b1000);

    // start during SHIFT is ignored
    @(negedge clk);
    a = 4'd4; b = 4'd10; m = 1'b0; start = 1'b1;
    @(posedge clk);
    sb.push_back(ref_calc(4'd4, 4'd10, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        check_result("ignore");
      end
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_s_lit", 32'(s), 32'b1110);

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 4'd4; b = 4'd10; m = 1'b0; start = 1'b1;
    @(posedge clk);
    sb.push_back(ref_calc(4'd4, 4'd10, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_s", 32'(s), 32'd0);
    check("arst_c", 32'(c), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);
    rst_n = 1'b1;
    run_op("sub_5_3", 4'd5, 4'd3, 1'b1);

    // start held high through DONE: back-to-back accept
    @(negedge clk);
    a = 4'd7; b = 4'd12; m = 1'b0; start = 1'b1;
    @(posedge clk);
    sb.push_back(ref_calc(4'd7, 4'd12, 1'b0));
    @(negedge clk);
    a = 4'd2; b = 4'd3; m = 1'b0;
    check("b2b_busy1", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_lat1", 32'(n), 32'(W));
    check_result("b2b_first");
    @(posedge clk);
    sb.push_back(ref_calc(4'd2, 4'd3, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_busy2", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_lat2", 32'(n), 32'(W));
    check("b2b_s_lit", 32'(s), 32'b0101);
    check_result("b2b_second");

    // exhaustive sweep
    for (int mi = 0; mi < 2; mi++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          run_op("sweep", W'(ai), W'(bi), mi[0]);
        end
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
